// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 bus monitor: instruction masks, DDRAM
// geometry, timing defaults at 50 MHz, FSM states and address helpers.
package lcd_pkg;

    // Execution and strobe timing at a 50 MHz system clock
    localparam int T_CMD_CYC_50M    = 2000;   // 40 us
    localparam int T_CLR_CYC_50M    = 82000;  // 1.64 ms
    localparam int T_EN_MIN_CYC_50M = 23;     // 450 ns

    // DDRAM geometry, two-line mode
    localparam logic [6:0] LINE1_BASE = 7'h00;
    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam logic [6:0] LINE1_WRAP = 7'h27;
    localparam logic [6:0] LINE2_WRAP = 7'h67;
    localparam int         LINE_LEN   = 16;
    localparam int         NUM_SLOTS  = 2 * LINE_LEN;
    localparam int         SLOT_W     = $clog2(NUM_SLOTS);

    localparam logic [7:0] SPACE_CHAR = 8'h20;

    // Instruction masks; the highest set bit selects the instruction
    localparam logic [7:0] MASK_SET_DDRAM = 8'h80;
    localparam logic [7:0] MASK_SET_CGRAM = 8'h40;
    localparam logic [7:0] MASK_FUNC_SET  = 8'h20;
    localparam logic [7:0] MASK_SHIFT     = 8'h10;
    localparam logic [7:0] MASK_DISP_CTRL = 8'h08;
    localparam logic [7:0] MASK_ENTRY     = 8'h04;
    localparam logic [7:0] MASK_HOME      = 8'h02;
    localparam logic [7:0] MASK_CLEAR     = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_CLEAR_FILL
    } lcd_state_e;

    typedef enum logic [3:0] {
        INS_NOP,
        INS_CLEAR,
        INS_HOME,
        INS_ENTRY,
        INS_DISP,
        INS_SHIFT,
        INS_FUNC,
        INS_CGRAM,
        INS_DDRAM
    } lcd_ins_e;

    // Classify an instruction byte by its highest set bit
    function automatic lcd_ins_e ins_class(input logic [7:0] b);
        if ((b & MASK_SET_DDRAM) != 8'h00) return INS_DDRAM;
        if ((b & MASK_SET_CGRAM) != 8'h00) return INS_CGRAM;
        if ((b & MASK_FUNC_SET)  != 8'h00) return INS_FUNC;
        if ((b & MASK_SHIFT)     != 8'h00) return INS_SHIFT;
        if ((b & MASK_DISP_CTRL) != 8'h00) return INS_DISP;
        if ((b & MASK_ENTRY)     != 8'h00) return INS_ENTRY;
        if ((b & MASK_HOME)      != 8'h00) return INS_HOME;
        if ((b & MASK_CLEAR)     != 8'h00) return INS_CLEAR;
        return INS_NOP;
    endfunction

    // Two-line address counter: ...0x27 -> 0x40 ...0x67 -> 0x00
    function automatic logic [6:0] addr_inc(input logic [6:0] a);
        if (a == LINE1_WRAP) return LINE2_BASE;
        if (a == LINE2_WRAP) return LINE1_BASE;
        return a + 7'd1;
    endfunction

    // Exact reverse of addr_inc
    function automatic logic [6:0] addr_dec(input logic [6:0] a);
        if (a == LINE1_BASE) return LINE2_WRAP;
        if (a == LINE2_BASE) return LINE1_WRAP;
        return a - 7'd1;
    endfunction

    function automatic logic [6:0] addr_step(input logic [6:0] a, input logic up);
        return up ? addr_inc(a) : addr_dec(a);
    endfunction

    // True when the address falls in the visible 16 columns of either line
    function automatic logic slot_hit(input logic [6:0] a);
        return (a[6:4] == LINE1_BASE[6:4]) || (a[6:4] == LINE2_BASE[6:4]);
    endfunction

    // Shadow slot for a visible address: line 1 -> 0..15, line 2 -> 16..31
    function automatic logic [SLOT_W-1:0] slot_of(input logic [6:0] a);
        return a[6] ? SLOT_W'(LINE_LEN) + {1'b0, a[3:0]} : {1'b0, a[3:0]};
    endfunction

endpackage

// File: rtl/lcd_ddram_shadow.sv
// 32x8 shadow of the visible DDRAM: one write port, one registered read port.
// A read of the slot being written in the same cycle returns the old value.
module lcd_ddram_shadow
    import lcd_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [SLOT_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [SLOT_W-1:0] rd_addr,
    output logic [7:0]        rd_char
);

    logic [7:0] mem [0:NUM_SLOTS-1];

    // Write port
    // NOTE: the array has no reset; the top-level clear fill initialises it, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port
    // NOTE: non-blocking here is what gives read-before-write when both ports hit one slot.
    always_ff @(posedge clk) begin
        rd_char <= mem[rd_addr];
    end

endmodule

// File: rtl/lcd_bus_monitor.sv
// Passive HD44780 bus responder: synchronises the bus, qualifies each EN
// falling edge, decodes accepted writes into a shadow DDRAM / cursor /
// display-on state and raises sticky protocol-violation flags.
module lcd_bus_monitor
    import lcd_pkg::*;
#(
    parameter int T_CMD_CYC    = T_CMD_CYC_50M,
    parameter int T_CLR_CYC    = T_CLR_CYC_50M,
    parameter int T_EN_MIN_CYC = T_EN_MIN_CYC_50M
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  lcd_data,
    input  logic        lcd_rs,
    input  logic        lcd_rw,
    input  logic        lcd_en,
    input  logic [4:0]  rd_addr,
    output logic [7:0]  rd_char,
    output logic [6:0]  cursor_addr,
    output logic        disp_on,
    output logic        busy,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte,
    output logic        cmd_rs,
    output logic        err_busy,
    output logic        err_en_short,
    output logic        err_rw,
    input  logic        err_clr
);

    localparam int T_MAX = (T_CLR_CYC > T_CMD_CYC) ? T_CLR_CYC : T_CMD_CYC;
    localparam int TMR_W = $clog2(T_MAX + 1);
    localparam int ENW_W = $clog2(T_EN_MIN_CYC + 1);

    localparam logic [TMR_W-1:0]  TMR_CMD   = TMR_W'(T_CMD_CYC);
    localparam logic [TMR_W-1:0]  TMR_CLR   = TMR_W'(T_CLR_CYC);
    localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
    localparam logic [ENW_W-1:0]  EN_MIN    = ENW_W'(T_EN_MIN_CYC);
    localparam logic [ENW_W-1:0]  ENW_ONE   = ENW_W'(1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

    // Synchronisers, second stage named s_*
    logic [7:0] sync_data, s_data;
    logic       sync_rs, sync_rw, sync_en;
    logic       s_rs, s_rw, s_en, s_en_q;

    // Bus hold register, EN width counter, falling-edge capture
    logic [7:0]       hold_data;
    logic             hold_rs;
    logic [ENW_W-1:0] en_width;
    logic             en_fall;
    logic             fall_q, fall_rw_q, fall_short_q;
    logic             fall_rw, fall_short, fall_busy, accept;

    // FSM and datapath
    lcd_state_e        state, state_n;
    logic [SLOT_W-1:0] fill_idx, fill_idx_n;
    logic [6:0]        cursor_n;
    logic              inc_mode, inc_mode_n;
    logic              disp_on_n;
    logic [TMR_W-1:0]  timer;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              ram_we;
    logic [SLOT_W-1:0] ram_waddr;
    logic [7:0]        ram_wdata;

    // Two-stage synchronisers, cleared to idle-low
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_data <= '0;
            sync_rs   <= 1'b0;
            sync_rw   <= 1'b0;
            sync_en   <= 1'b0;
            s_data    <= '0;
            s_rs      <= 1'b0;
            s_rw      <= 1'b0;
            s_en      <= 1'b0;
            s_en_q    <= 1'b0;
        end else begin
            sync_data <= lcd_data;
            sync_rs   <= lcd_rs;
            sync_rw   <= lcd_rw;
            sync_en   <= lcd_en;
            s_data    <= sync_data;
            s_rs      <= sync_rs;
            s_rw      <= sync_rw;
            s_en      <= sync_en;
            s_en_q    <= s_en;
        end
    end

    // Hold the last byte/RS seen while EN is high
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_data <= '0;
            hold_rs   <= 1'b0;
        end else if (s_en) begin
            hold_data <= s_data;
            hold_rs   <= s_rs;
        end
    end

    // EN high-width counter, saturating at the minimum legal width
    always_ff @(posedge clk) begin
        if (reset || !s_en) begin
            en_width <= '0;
        end else if (en_width != EN_MIN) begin
            en_width <= en_width + ENW_ONE;
        end
    end

    // The counter still holds the full width in the cycle s_en first reads low
    assign en_fall = s_en_q & ~s_en;

    // Register the falling edge together with the facts needed to judge it
    always_ff @(posedge clk) begin
        if (reset) begin
            fall_q       <= 1'b0;
            fall_rw_q    <= 1'b0;
            fall_short_q <= 1'b0;
        end else begin
            fall_q       <= en_fall;
            fall_rw_q    <= s_rw;
            fall_short_q <= (en_width < EN_MIN);
        end
    end

    // Judge the edge in priority order: read, short strobe, busy, accept
    always_comb begin
        fall_rw    = fall_q & fall_rw_q;
        fall_short = fall_q & ~fall_rw_q & fall_short_q;
        fall_busy  = fall_q & ~fall_rw_q & ~fall_short_q & (busy | (state != ST_IDLE));
        accept     = fall_q & ~fall_rw_q & ~fall_short_q & ~busy & (state == ST_IDLE);
    end

    // FSM state register; reset (also mid-fill) restarts the clear fill at slot 0
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_CLEAR_FILL;
            fill_idx <= '0;
        end else begin
            state    <= state_n;
            fill_idx <= fill_idx_n;
        end
    end

    // Next state, instruction decode and shadow-RAM write control
    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_n    = state;
        fill_idx_n = fill_idx;
        cursor_n   = cursor_addr;
        inc_mode_n = inc_mode;
        disp_on_n  = disp_on;
        tmr_load   = 1'b0;
        tmr_val    = TMR_CMD;
        ram_we     = 1'b0;
        ram_waddr  = '0;
        ram_wdata  = '0;

        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n  = ST_DECODE;
                    tmr_load = 1'b1;
                    if (hold_rs) begin
                        ram_we    = slot_hit(cursor_addr);
                        ram_waddr = slot_of(cursor_addr);
                        ram_wdata = hold_data;
                        cursor_n  = addr_step(cursor_addr, inc_mode);
                    end else begin
                        unique case (ins_class(hold_data))
                            INS_DDRAM: cursor_n = hold_data[6:0];
                            INS_SHIFT: begin
                                // Only cursor moves matter; display shifts are ignored
                                if (!hold_data[3]) begin
                                    cursor_n = addr_step(cursor_addr, hold_data[2]);
                                end
                            end
                            INS_DISP:  disp_on_n  = hold_data[2];
                            INS_ENTRY: inc_mode_n = hold_data[1];
                            INS_HOME: begin
                                cursor_n = '0;
                                tmr_val  = TMR_CLR;
                            end
                            INS_CLEAR: begin
                                cursor_n   = '0;
                                inc_mode_n = 1'b1;
                                tmr_val    = TMR_CLR;
                            end
                            INS_NOP:   tmr_load = 1'b0;
                            default:   ;  // CGRAM address and function set leave no trace
                        endcase
                    end
                end
            end

            ST_DECODE: begin
                fill_idx_n = '0;
                if (!cmd_rs && (cmd_byte == MASK_CLEAR)) begin
                    state_n = ST_CLEAR_FILL;
                end else begin
                    state_n = ST_IDLE;
                end
            end

            ST_CLEAR_FILL: begin
                ram_we     = 1'b1;
                ram_waddr  = fill_idx;
                ram_wdata  = SPACE_CHAR;
                fill_idx_n = fill_idx + SLOT_W'(1);
                if (fill_idx == LAST_SLOT) begin
                    state_n = ST_IDLE;
                end
            end

            default: state_n = ST_IDLE;
        endcase
    end

    // Architectural state, execution timer and command report
    always_ff @(posedge clk) begin
        if (reset) begin
            cursor_addr <= '0;
            inc_mode    <= 1'b1;
            disp_on     <= 1'b0;
            timer       <= TMR_CLR;
            busy        <= 1'b1;
            cmd_valid   <= 1'b0;
            cmd_byte    <= '0;
            cmd_rs      <= 1'b0;
        end else begin
            cursor_addr <= cursor_n;
            inc_mode    <= inc_mode_n;
            disp_on     <= disp_on_n;
            if (tmr_load) begin
                timer <= tmr_val;
            end else if (timer != '0) begin
                timer <= timer - TMR_ONE;
            end
            // One cycle behind the timer, so busy is high for exactly the loaded count
            busy      <= (timer != '0);
            cmd_valid <= accept;
            if (accept) begin
                cmd_byte <= hold_data;
                cmd_rs   <= hold_rs;
            end
        end
    end

    // Sticky error flags; a set in the same cycle as err_clr wins
    always_ff @(posedge clk) begin
        if (reset) begin
            err_rw       <= 1'b0;
            err_en_short <= 1'b0;
            err_busy     <= 1'b0;
        end else begin
            if (fall_rw) begin
                err_rw <= 1'b1;
            end else if (err_clr) begin
                err_rw <= 1'b0;
            end
            if (fall_short) begin
                err_en_short <= 1'b1;
            end else if (err_clr) begin
                err_en_short <= 1'b0;
            end
            if (fall_busy) begin
                err_busy <= 1'b1;
            end else if (err_clr) begin
                err_busy <= 1'b0;
            end
        end
    end

    lcd_ddram_shadow u_shadow (
        .clk     (clk),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .rd_addr (rd_addr),
        .rd_char (rd_char)
    );

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Scoreboard bench for lcd_bus_monitor: stimulus pushes expected command
// reports and shadow reads into queues, a monitor pops and compares them.
module tb_lcd_bus_monitor;

    localparam int T_CMD = 100;
    localparam int T_CLR = 300;
    localparam int T_EN  = 23;
    localparam int W_OK  = 30;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_en;
    logic [4:0] rd_addr;
    logic [7:0] rd_char;
    logic [6:0] cursor_addr;
    logic       disp_on, busy, cmd_valid, cmd_rs;
    logic [7:0] cmd_byte;
    logic       err_busy, err_en_short, err_rw, err_clr;

    always #5 clk = ~clk;

    lcd_bus_monitor #(
        .T_CMD_CYC    (T_CMD),
        .T_CLR_CYC    (T_CLR),
        .T_EN_MIN_CYC (T_EN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .lcd_data     (lcd_data),
        .lcd_rs       (lcd_rs),
        .lcd_rw       (lcd_rw),
        .lcd_en       (lcd_en),
        .rd_addr      (rd_addr),
        .rd_char      (rd_char),
        .cursor_addr  (cursor_addr),
        .disp_on      (disp_on),
        .busy         (busy),
        .cmd_valid    (cmd_valid),
        .cmd_byte     (cmd_byte),
        .cmd_rs       (cmd_rs),
        .err_busy     (err_busy),
        .err_en_short (err_en_short),
        .err_rw       (err_rw),
        .err_clr      (err_clr)
    );

    int n_tests    = 0;
    int n_fail     = 0;
    int cmd_pulses = 0;
    int cmd_pushed = 0;

    logic [8:0]  exp_cmd [$];   // {rs, byte}
    logic [12:0] exp_rd  [$];   // {slot, char}
    logic        rd_req = 1'b0;
    logic        rd_vld = 1'b0;

    always @(posedge clk) rd_vld <= rd_req;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every command pulse and every read response
    initial begin : monitor
        logic [8:0]  e;
        logic [12:0] r;
        forever begin
            @(negedge clk);
            if (cmd_valid === 1'b1) begin
                cmd_pulses++;
                check("cmd_expected", 32'(exp_cmd.size() != 0), 1);
                if (exp_cmd.size() != 0) begin
                    e = exp_cmd.pop_front();
                    check("cmd_rs_byte", {cmd_rs, cmd_byte}, e);
                end
            end
            if (rd_vld && exp_rd.size() != 0) begin
                r = exp_rd.pop_front();
                check($sformatf("rd_char_slot%0d", r[12:8]), rd_char, r[7:0]);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic bus_pulse(input logic rs, input logic [7:0] d, input logic rw, input int width);
        @(negedge clk);
        lcd_rs   = rs;
        lcd_rw   = rw;
        lcd_data = d;
        repeat (2) @(negedge clk);
        lcd_en = 1'b1;
        repeat (width) @(negedge clk);
        lcd_en = 1'b0;
        repeat (2) @(negedge clk);
        lcd_rw = 1'b0;
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while (busy && cyc < 4 * T_CLR) begin
            @(negedge clk);
            cyc++;
        end
        check("busy_timeout", busy, 0);
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
        wait_idle();
        repeat (4) @(negedge clk);
    endtask

    task automatic expect_cmd(input logic rs, input logic [7:0] d);
        exp_cmd.push_back({rs, d});
        cmd_pushed++;
    endtask

    task automatic send(input logic rs, input logic [7:0] d);
        expect_cmd(rs, d);
        bus_pulse(rs, d, 1'b0, W_OK);
        settle();
    endtask

    task automatic read_slot(input int a, input logic [7:0] e);
        @(negedge clk);
        rd_addr = 5'(a);
        rd_req  = 1'b1;
        exp_rd.push_back({5'(a), e});
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic measure_busy(input string name, input int exp_len);
        int cyc = 0;
        int len = 0;
        while (!busy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        while (busy && len < 4 * exp_len + 100) begin
            @(negedge clk);
            len++;
        end
        check(name, len, exp_len);
    endtask

    task automatic pulse_err_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin : stim
        reset    = 1'b1;
        lcd_data = 8'h00;
        lcd_rs   = 1'b0;
        lcd_rw   = 1'b0;
        lcd_en   = 1'b0;
        rd_addr  = 5'd0;
        err_clr  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", busy, 1);
        check("rst_cursor", cursor_addr, 0);
        check("rst_disp_on", disp_on, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd", {cmd_rs, cmd_byte}, 0);
        check("rst_errs", {err_busy, err_en_short, err_rw}, 0);
        reset = 1'b0;
        @(negedge clk);
        measure_busy("rst_busy_len", T_CLR);
        for (int i = 0; i < 32; i++) read_slot(i, 8'h20);
        check("init_cursor", cursor_addr, 0);
        check("init_disp_on", disp_on, 0);

        // Init sequence then "DDFS"
        send(1'b0, 8'h38);
        send(1'b0, 8'h0C);
        check("disp_on_set", disp_on, 1);
        send(1'b0, 8'h06);
        send(1'b0, 8'h01);
        check("clear_cursor", cursor_addr, 0);
        expect_cmd(1'b1, 8'h44);
        bus_pulse(1'b1, 8'h44, 1'b0, W_OK);
        measure_busy("data_busy_len", T_CMD);
        settle();
        send(1'b1, 8'h44);
        send(1'b1, 8'h46);
        send(1'b1, 8'h53);
        check("ddfs_cursor", cursor_addr, 7'h04);
        check("ddfs_disp_on", disp_on, 1);
        read_slot(0, 8'h44);
        read_slot(1, 8'h44);
        read_slot(2, 8'h46);
        read_slot(3, 8'h53);
        read_slot(4, 8'h20);

        // Second line
        send(1'b0, 8'hC0);
        send(1'b1, 8'h35);
        send(1'b1, 8'h30);
        check("line2_cursor", cursor_addr, 7'h42);
        read_slot(16, 8'h35);
        read_slot(17, 8'h30);

        // Increment wrap 0x27 -> 0x40, write at 0x27 lands nowhere
        send(1'b0, 8'hA7);
        send(1'b1, 8'h41);
        check("wrap_27_40", cursor_addr, 7'h40);
        read_slot(16, 8'h35);

        // Decrement wrap 0x00 -> 0x67
        send(1'b0, 8'h04);
        send(1'b0, 8'h80);
        send(1'b1, 8'h42);
        check("wrap_00_67", cursor_addr, 7'h67);
        read_slot(0, 8'h42);

        // Increment wrap 0x67 -> 0x00
        send(1'b0, 8'h06);
        send(1'b0, 8'hE7);
        send(1'b1, 8'h43);
        check("wrap_67_00", cursor_addr, 7'h00);

        // Cursor shift right then left
        send(1'b0, 8'h14);
        check("shift_right", cursor_addr, 7'h01);
        send(1'b0, 8'h10);
        check("shift_left", cursor_addr, 7'h00);

        // No-op: reported but starts no timer
        expect_cmd(1'b0, 8'h00);
        bus_pulse(1'b0, 8'h00, 1'b0, W_OK);
        repeat (6) @(negedge clk);
        check("nop_busy", busy, 0);

        // Busy violation
        send(1'b0, 8'h80);
        expect_cmd(1'b1, 8'h51);
        bus_pulse(1'b1, 8'h51, 1'b0, W_OK);
        bus_pulse(1'b1, 8'h5A, 1'b0, W_OK);
        repeat (6) @(negedge clk);
        check("err_busy_set", err_busy, 1);
        settle();
        check("busy_cursor", cursor_addr, 7'h01);
        read_slot(0, 8'h51);
        read_slot(1, 8'h44);
        pulse_err_clr();
        check("err_busy_clr", err_busy, 0);

        // Short EN pulses: 10 cycles, then one below the minimum
        bus_pulse(1'b1, 8'h59, 1'b0, 10);
        repeat (6) @(negedge clk);
        check("err_short_10", err_en_short, 1);
        check("short_no_busy_err", err_busy, 0);
        pulse_err_clr();
        check("err_short_clr", err_en_short, 0);
        bus_pulse(1'b1, 8'h59, 1'b0, T_EN - 1);
        repeat (6) @(negedge clk);
        check("err_short_min_m1", err_en_short, 1);
        check("short_cursor", cursor_addr, 7'h01);
        pulse_err_clr();

        // Exactly the minimum width is accepted
        expect_cmd(1'b1, 8'h4B);
        bus_pulse(1'b1, 8'h4B, 1'b0, T_EN);
        settle();
        check("min_width_ok", err_en_short, 0);
        check("min_width_cursor", cursor_addr, 7'h02);

        // Read strobe on the bus
        bus_pulse(1'b1, 8'h52, 1'b1, W_OK);
        repeat (6) @(negedge clk);
        check("err_rw_set", err_rw, 1);
        check("rw_cursor", cursor_addr, 7'h02);
        pulse_err_clr();
        check("err_rw_clr", err_rw, 0);
        read_slot(0, 8'h51);
        read_slot(1, 8'h4B);
        read_slot(2, 8'h46);
        read_slot(3, 8'h53);

        // Reset during the clear fill
        expect_cmd(1'b0, 8'h01);
        bus_pulse(1'b0, 8'h01, 1'b0, W_OK);
        repeat (10) @(negedge clk);
        check("fill_busy", busy, 1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("midfill_rst_busy", busy, 1);
        settle();
        for (int i = 0; i < 32; i++) read_slot(i, 8'h20);
        check("midfill_cursor", cursor_addr, 0);
        check("midfill_disp_on", disp_on, 0);

        repeat (4) @(negedge clk);
        check("cmd_pulse_count", cmd_pulses, cmd_pushed);
        check("cmd_queue_empty", exp_cmd.size(), 0);
        check("rd_queue_empty", exp_rd.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
